bakraid_colmix: RTL and testbench



---
 rtl/bakraid_colmix_pkg.sv | 32 +++
 rtl/bakraid_colmix_cmp.sv | 22 ++
 rtl/bakraid_colmix.sv | 140 ++++++++++++++
 tb/tb_bakraid_colmix.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bakraid_colmix_pkg.sv
// rtl/bakraid_colmix_pkg.sv - shared types and constants for the bakraid colour mixer
//
// Purpose : layer record type, layer bit positions and the transparency test
//           used by bakraid_colmix and bakraid_colmix_cmp.
// Ports   : none (package).
package bakraid_colmix_pkg;

  localparam int PIX_W = 11;
  localparam int PRI_W = 4;

  // Bit positions inside the optional LAYER_EN mask.
  localparam int LYR_BG0    = 0;
  localparam int LYR_BG1    = 1;
  localparam int LYR_BG2    = 2;
  localparam int LYR_SPR    = 3;
  localparam int LYR_TXT    = 4;
  localparam int NUM_LAYERS = 5;

  // A palette index whose low nibble equals this value is transparent.
  localparam logic [3:0] TRANSPARENT_NIBBLE = 4'h0;

  typedef struct packed {
    logic [PIX_W-1:0] pix;
    logic [PRI_W-1:0] pri;
    logic             opaque;
  } layer_t;

  function automatic logic nibble_opaque(input logic [3:0] nib);
    return nib != TRANSPARENT_NIBBLE;
  endfunction

endpackage

// File: rtl/bakraid_colmix_cmp.sv
// rtl/bakraid_colmix_cmp.sv - two-input layer priority compare, ties favour A
//
// Purpose : returns whichever of two layers is visible. A wins when it is
//           opaque and B is either transparent or of equal/lower priority.
//           If neither is opaque the result is B (transparent).
// Ports   : a_i   - favoured layer
//           b_i   - other layer
//           win_o - winning layer record
module bakraid_colmix_cmp
  import bakraid_colmix_pkg::*;
(
  input  layer_t a_i,
  input  layer_t b_i,
  output layer_t win_o
);

  logic a_wins;

  assign a_wins = a_i.opaque && (!b_i.opaque || (a_i.pri >= b_i.pri));
  assign win_o  = a_wins ? a_i : b_i;

endmodule

// File: rtl/bakraid_colmix.sv
// rtl/bakraid_colmix.sv - 3-stage priority mixer feeding the palette lookup
//
// Purpose : resolves transparency/priority of three BG layers, sprites and
//           text into one palette index, with blanking delayed to match.
//           Optional macro BAKRAID_COLMIX_LAYER_MASK_EN adds LAYER_EN[4:0].
// Ports   : CLK96, RESET96 (sync, active high), PIXEL_CEN (pipeline enable)
//           LHBL/LVBL blank inputs, BGn_PIX/BGn_PRI, SPR_PIX/SPR_PRI, TXT_PIX
//           PIXEL resolved index, LHBL_DLY/LVBL_DLY blanking aligned to PIXEL
//           LAYER_EN per-layer enable (only with BAKRAID_COLMIX_LAYER_MASK_EN)
module bakraid_colmix
  import bakraid_colmix_pkg::*;
#(
  parameter logic [10:0] BACKDROP = 11'h000,
  parameter int          LATENCY  = 3
) (
  input  logic        CLK96,
  input  logic        RESET96,
  input  logic        PIXEL_CEN,
  input  logic        LHBL,
  input  logic        LVBL,
  input  logic [10:0] BG0_PIX,
  input  logic [10:0] BG1_PIX,
  input  logic [10:0] BG2_PIX,
  input  logic [10:0] SPR_PIX,
  input  logic [3:0]  BG0_PRI,
  input  logic [3:0]  BG1_PRI,
  input  logic [3:0]  BG2_PRI,
  input  logic [3:0]  SPR_PRI,
  input  logic [10:0] TXT_PIX,
`ifdef BAKRAID_COLMIX_LAYER_MASK_EN
  input  logic [4:0]  LAYER_EN,
`endif
  output logic [10:0] PIXEL,
  output logic        LHBL_DLY,
  output logic        LVBL_DLY
);

  // The pipeline below is hand-built as exactly three registered stages.
  generate
    if (LATENCY != 3) begin : g_bad_latency
      $error("bakraid_colmix: LATENCY must be 3");
    end
  endgenerate

  logic [NUM_LAYERS-1:0] layer_en;
`ifdef BAKRAID_COLMIX_LAYER_MASK_EN
  assign layer_en = LAYER_EN;
`else
  assign layer_en = '1;
`endif

  // Stage 1: registered inputs with opaque flags.
  layer_t      bg0_s1_d, bg1_s1_d, bg2_s1_d, spr_s1_d;
  layer_t      bg0_s1_q, bg1_s1_q, bg2_s1_q, spr_s1_q;
  logic [10:0] txt_pix_s1_q;
  logic        txt_opq_s1_d, txt_opq_s1_q;
  logic        lhbl_s1_q, lvbl_s1_q;

  always_comb begin
    bg0_s1_d     = '{pix: BG0_PIX, pri: BG0_PRI,
                     opaque: nibble_opaque(BG0_PIX[3:0]) & layer_en[LYR_BG0]};
    bg1_s1_d     = '{pix: BG1_PIX, pri: BG1_PRI,
                     opaque: nibble_opaque(BG1_PIX[3:0]) & layer_en[LYR_BG1]};
    bg2_s1_d     = '{pix: BG2_PIX, pri: BG2_PRI,
                     opaque: nibble_opaque(BG2_PIX[3:0]) & layer_en[LYR_BG2]};
    spr_s1_d     = '{pix: SPR_PIX, pri: SPR_PRI,
                     opaque: nibble_opaque(SPR_PIX[3:0]) & layer_en[LYR_SPR]};
    txt_opq_s1_d = nibble_opaque(TXT_PIX[3:0]) & layer_en[LYR_TXT];
  end

  // Stage 2: BG tree; BG0 vs BG1 first so BG0 wins ties, then that vs BG2.
  layer_t      bg01_win, bg_win_s2_d;
  layer_t      bg_win_s2_q, spr_s2_q;
  logic [10:0] txt_pix_s2_q;
  logic        txt_opq_s2_q;
  logic        lhbl_s2_q, lvbl_s2_q;

  bakraid_colmix_cmp u_cmp_bg01 (.a_i(bg0_s1_q), .b_i(bg1_s1_q), .win_o(bg01_win));
  bakraid_colmix_cmp u_cmp_bg2  (.a_i(bg01_win), .b_i(bg2_s1_q), .win_o(bg_win_s2_d));

  // Stage 3: sprite is the favoured side, so it wins priority ties with BG.
  layer_t      fin_win;
  logic [10:0] pixel_d, pixel_q;
  logic        lhbl_dly_q, lvbl_dly_q;

  bakraid_colmix_cmp u_cmp_spr (.a_i(spr_s2_q), .b_i(bg_win_s2_q), .win_o(fin_win));

  always_comb begin
    pixel_d = BACKDROP;
    if (lhbl_s2_q && lvbl_s2_q) begin
      if (txt_opq_s2_q)        pixel_d = txt_pix_s2_q;
      else if (fin_win.opaque) pixel_d = fin_win.pix;
    end
  end

  always_ff @(posedge CLK96) begin
    if (RESET96) begin
      bg0_s1_q     <= '0;
      bg1_s1_q     <= '0;
      bg2_s1_q     <= '0;
      spr_s1_q     <= '0;
      txt_pix_s1_q <= '0;
      txt_opq_s1_q <= 1'b0;
      lhbl_s1_q    <= 1'b0;
      lvbl_s1_q    <= 1'b0;
      bg_win_s2_q  <= '0;
      spr_s2_q     <= '0;
      txt_pix_s2_q <= '0;
      txt_opq_s2_q <= 1'b0;
      lhbl_s2_q    <= 1'b0;
      lvbl_s2_q    <= 1'b0;
      pixel_q      <= BACKDROP;
      lhbl_dly_q   <= 1'b0;
      lvbl_dly_q   <= 1'b0;
    end else if (PIXEL_CEN) begin
      bg0_s1_q     <= bg0_s1_d;
      bg1_s1_q     <= bg1_s1_d;
      bg2_s1_q     <= bg2_s1_d;
      spr_s1_q     <= spr_s1_d;
      txt_pix_s1_q <= TXT_PIX;
      txt_opq_s1_q <= txt_opq_s1_d;
      lhbl_s1_q    <= LHBL;
      lvbl_s1_q    <= LVBL;
      bg_win_s2_q  <= bg_win_s2_d;
      spr_s2_q     <= spr_s1_q;
      txt_pix_s2_q <= txt_pix_s1_q;
      txt_opq_s2_q <= txt_opq_s1_q;
      lhbl_s2_q    <= lhbl_s1_q;
      lvbl_s2_q    <= lvbl_s1_q;
      pixel_q      <= pixel_d;
      lhbl_dly_q   <= lhbl_s2_q;
      lvbl_dly_q   <= lvbl_s2_q;
    end
  end

  assign PIXEL    = pixel_q;
  assign LHBL_DLY = lhbl_dly_q;
  assign LVBL_DLY = lvbl_dly_q;

endmodule

// File: tb/tb_bakraid_colmix.sv
// tb/tb_bakraid_colmix.sv - scoreboard bench for bakraid_colmix
module tb_bakraid_colmix;

  localparam logic [10:0] BACKDROP = 11'h000;

  logic        CLK96 = 1'b0;
  logic        RESET96 = 1'b1;
  logic        PIXEL_CEN = 1'b0;
  logic        LHBL = 1'b0, LVBL = 1'b0;
  logic [10:0] BG0_PIX = '0, BG1_PIX = '0, BG2_PIX = '0, SPR_PIX = '0, TXT_PIX = '0;
  logic [3:0]  BG0_PRI = '0, BG1_PRI = '0, BG2_PRI = '0, SPR_PRI = '0;
`ifdef BAKRAID_COLMIX_LAYER_MASK_EN
  logic [4:0]  LAYER_EN = 5'h1F;
`endif
  logic [10:0] PIXEL;
  logic        LHBL_DLY, LVBL_DLY;

  always #5 CLK96 = ~CLK96;

  bakraid_colmix #(.BACKDROP(BACKDROP), .LATENCY(3)) dut (
    .CLK96(CLK96), .RESET96(RESET96), .PIXEL_CEN(PIXEL_CEN),
    .LHBL(LHBL), .LVBL(LVBL),
    .BG0_PIX(BG0_PIX), .BG1_PIX(BG1_PIX), .BG2_PIX(BG2_PIX), .SPR_PIX(SPR_PIX),
    .BG0_PRI(BG0_PRI), .BG1_PRI(BG1_PRI), .BG2_PRI(BG2_PRI), .SPR_PRI(SPR_PRI),
    .TXT_PIX(TXT_PIX),
`ifdef BAKRAID_COLMIX_LAYER_MASK_EN
    .LAYER_EN(LAYER_EN),
`endif
    .PIXEL(PIXEL), .LHBL_DLY(LHBL_DLY), .LVBL_DLY(LVBL_DLY)
  );

  // Layer order in pix[]: 0..2 BG, 3 sprite, 4 text.
  typedef struct {
    logic [10:0] pix [5];
    logic [3:0]  pri [4];
    logic        lhbl;
    logic        lvbl;
    logic [4:0]  en;
  } px_t;

  // Expected output word: {LHBL_DLY, LVBL_DLY, PIXEL}.
  logic [12:0] exp_q [$];
  int total = 0;
  int bad   = 0;

  function automatic px_t mk(input logic [10:0] b0, input logic [3:0] p0,
                             input logic [10:0] b1, input logic [3:0] p1,
                             input logic [10:0] b2, input logic [3:0] p2,
                             input logic [10:0] s,  input logic [3:0] ps,
                             input logic [10:0] t);
    px_t p;
    p.pix[0] = b0; p.pri[0] = p0;
    p.pix[1] = b1; p.pri[1] = p1;
    p.pix[2] = b2; p.pri[2] = p2;
    p.pix[3] = s;  p.pri[3] = ps;
    p.pix[4] = t;
    p.lhbl = 1'b1; p.lvbl = 1'b1; p.en = 5'h1F;
    return p;
  endfunction

  // Reference: text first, then the best BG (strictly higher priority
  // replaces; earlier layer keeps ties), sprite beats BG on >=.
  function automatic logic [12:0] model(input px_t p);
    bit          opq [5];
    int          best;
    logic [10:0] res;
    for (int i = 0; i < 5; i++) opq[i] = ((p.pix[i] % 16) != 0) && p.en[i];
    best = -1;
    for (int i = 0; i < 3; i++)
      if (opq[i] && (best < 0 || p.pri[i] > p.pri[best])) best = i;
    if (!p.lhbl || !p.lvbl)                                  res = BACKDROP;
    else if (opq[4])                                         res = p.pix[4];
    else if (opq[3] && (best < 0 || p.pri[3] >= p.pri[best])) res = p.pix[3];
    else if (best >= 0)                                      res = p.pix[best];
    else                                                     res = BACKDROP;
    return {p.lhbl, p.lvbl, res};
  endfunction

  function automatic px_t rnd_px();
    px_t p;
    for (int i = 0; i < 5; i++) begin
      p.pix[i] = 11'($urandom_range(0, 2047));
      if ($urandom_range(0, 9) < 4) p.pix[i][3:0] = 4'h0;
    end
    for (int i = 0; i < 4; i++)
      p.pri[i] = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                                             : 4'($urandom_range(0, 3));
    p.lhbl = ($urandom_range(0, 9) != 0);
    p.lvbl = ($urandom_range(0, 9) != 0);
`ifdef BAKRAID_COLMIX_LAYER_MASK_EN
    p.en = ($urandom_range(0, 2) == 0) ? 5'($urandom_range(0, 31)) : 5'h1F;
`else
    p.en = 5'h1F;
`endif
    return p;
  endfunction

  task automatic apply(input px_t p);
    BG0_PIX = p.pix[0]; BG0_PRI = p.pri[0];
    BG1_PIX = p.pix[1]; BG1_PRI = p.pri[1];
    BG2_PIX = p.pix[2]; BG2_PRI = p.pri[2];
    SPR_PIX = p.pix[3]; SPR_PRI = p.pri[3];
    TXT_PIX = p.pix[4];
    LHBL = p.lhbl; LVBL = p.lvbl;
`ifdef BAKRAID_COLMIX_LAYER_MASK_EN
    LAYER_EN = p.en;
`endif
  endtask

  // Issue one pixel enable (called at a negedge), then idle `gap` clocks.
  task automatic send(input px_t p, input int gap, input bit use_c, input logic [12:0] c);
    apply(p);
    RESET96   = 1'b0;
    PIXEL_CEN = 1'b1;
    exp_q.push_back(use_c ? c : model(p));
    @(negedge CLK96);
    PIXEL_CEN = 1'b0;
    repeat (gap) @(negedge CLK96);
  endtask

  task automatic sendc(input px_t p, input logic [12:0] c);
    send(p, 3, 1'b1, c);
  endtask

  // Reset with PIXEL_CEN high to show reset overrides; afterwards two
  // enables still emit blank backdrop while the cleared pipeline refills.
  task automatic do_reset(input int cycles);
    RESET96   = 1'b1;
    PIXEL_CEN = 1'b1;
    exp_q.delete();
    repeat (cycles) @(negedge CLK96);
    RESET96   = 1'b0;
    PIXEL_CEN = 1'b0;
    exp_q.push_back({2'b00, BACKDROP});
    exp_q.push_back({2'b00, BACKDROP});
  endtask

  task automatic check(input string name, input logic [12:0] e);
    total++;
    if ({LHBL_DLY, LVBL_DLY, PIXEL} !== e) begin
      bad++;
      $display("FAIL %s at %0t: got lhbl=%b lvbl=%b pix=%h, want lhbl=%b lvbl=%b pix=%h",
               name, $time, LHBL_DLY, LVBL_DLY, PIXEL, e[12], e[11], e[10:0]);
    end
  endtask

  // Monitor: pops one expectation per enable, checks reset state and
  // that outputs hold between enables.
  initial begin
    logic        r, c;
    logic [12:0] e, last;
    last = {2'b00, BACKDROP};
    forever begin
      @(posedge CLK96);
      r = RESET96;
      c = PIXEL_CEN;
      #1;
      if (r) begin
        check("reset", {2'b00, BACKDROP});
        last = {2'b00, BACKDROP};
      end else if (c) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL underflow at %0t: got pix=%h, want no output pending", $time, PIXEL);
        end else begin
          e = exp_q.pop_front();
          check("pixel", e);
          last = e;
        end
      end else begin
        check("hold", last);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish, want finish before 1ms");
    $fatal(1);
  end

  initial begin
    px_t p;
    @(negedge CLK96);
    do_reset(3);

    // Latency and LHBL alignment, enable every 4th clock.
    p = mk(11'h123, 2, 0, 0, 0, 0, 0, 0, 0);
    sendc(p, {2'b11, 11'h123});
    p.lhbl = 1'b0;
    sendc(p, {2'b01, BACKDROP});
    p.lhbl = 1'b1;
    sendc(p, {2'b11, 11'h123});

    // Priority and ties.
    p = mk(11'h101, 5, 11'h202, 5, 0, 0, 11'h303, 4, 0);
    sendc(p, {2'b11, 11'h101});
    p.pri[3] = 5;
    sendc(p, {2'b11, 11'h303});
    p.pix[4] = 11'h40F;
    sendc(p, {2'b11, 11'h40F});
    p = mk(0, 0, 11'h0A2, 3, 11'h0B3, 3, 0, 0, 0);
    sendc(p, {2'b11, 11'h0A2});
    p.pri[2] = 4;
    sendc(p, {2'b11, 11'h0B3});

    // Transparency.
    p = mk(11'h110, 7, 11'h220, 3, 11'h3F0, 1, 11'h4A0, 9, 11'h500);
    sendc(p, {2'b11, BACKDROP});
    p.pix[2] = 11'h7F1; p.pri[2] = 0;
    sendc(p, {2'b11, 11'h7F1});

    // Vertical blank then release.
    p = mk(11'h121, 1, 0, 0, 0, 0, 11'h331, 2, 0);
    p.lvbl = 1'b0;
    sendc(p, {2'b10, BACKDROP});
    p.lvbl = 1'b1;
    sendc(p, {2'b11, 11'h331});

    // Reset mid-line with opaque inputs in flight.
    p = mk(11'h155, 6, 0, 0, 0, 0, 0, 0, 0);
    sendc(p, {2'b11, 11'h155});
    sendc(p, {2'b11, 11'h155});
    do_reset(1);
    sendc(p, {2'b11, 11'h155});
    sendc(p, {2'b11, 11'h155});
    sendc(p, {2'b11, 11'h155});

`ifdef BAKRAID_COLMIX_LAYER_MASK_EN
    p = mk(11'h111, 1, 0, 0, 0, 0, 11'h3A5, 15, 0);
    p.en = 5'h17;
    sendc(p, {2'b11, 11'h111});
    p.en = 5'h1F;
    sendc(p, {2'b11, 11'h3A5});
`endif

    // Randomized traffic with variable enable spacing and occasional resets.
    for (int n = 0; n < 500; n++) begin
      if ($urandom_range(0, 79) == 0) begin
        apply(rnd_px());
        do_reset($urandom_range(1, 2));
      end
      send(rnd_px(), $urandom_range(0, 3), 1'b0, '0);
    end

    // Two extra enables flush the last checked pixels out.
    repeat (2) begin
      apply(rnd_px());
      PIXEL_CEN = 1'b1;
      @(negedge CLK96);
      PIXEL_CEN = 1'b0;
      @(negedge CLK96);
    end
    repeat (4) @(negedge CLK96);

    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending, want 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
